// File: rtl/cordic_gain_comp.sv
// ---------------------------------------------------------------------------
// cordic_gain_comp
// Gain-correction stage at the end of the CORDIC rotation pipeline. Scales the
// raw x/y results by K ~= 0.6072529350 (fixed point, GAIN_FRAC fraction bits)
// and forwards z unchanged, as a two-stage stallable valid/ready pipeline.
//
// Optional feature macro: CORDIC_GAIN_ROUND_EN
//   defined   : round-half-up (toward +inf) before the fractional shift
//   undefined : plain arithmetic-shift truncation (floor)
//
// Ports
//   aclk, aresetn              clock (rising edge), async active-low reset
//   tvalid_data_i/tready_data_i  upstream handshake (tready is combinational)
//   x_i, y_i                   raw CORDIC x/y, signed DATA_WIDTH
//   z_i                        residual angle, 32 bits
//   tvalid_data_o/tready_data_o  downstream handshake
//   x_o, y_o                   gain-corrected x/y, signed DATA_WIDTH
//   z_o                        z_i delayed to line up with x_o/y_o
// ---------------------------------------------------------------------------
module cordic_gain_comp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned GAIN_FRAC  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  tvalid_data_i,
    output logic                  tready_data_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic [31:0]           z_i,
    output logic                  tvalid_data_o,
    input  logic                  tready_data_o,
    output logic [DATA_WIDTH-1:0] x_o,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic [31:0]           z_o
);

    localparam int unsigned PW    = DATA_WIDTH + GAIN_FRAC + 1;
    localparam int unsigned EXT_W = PW - DATA_WIDTH;
    localparam real         K_REAL = 0.6072529350;
    localparam real         SCALE  = real'(64'd1 << GAIN_FRAC);

    // K_Q = round(K * 2^GAIN_FRAC); positive, so the top bit of the signed form is 0
    localparam logic signed [PW-1:0] K_Q = PW'($rtoi(K_REAL * SCALE + 0.5));

`ifdef CORDIC_GAIN_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (GAIN_FRAC - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    logic                  r_v1;
    logic                  r_v2;
    logic signed [PW-1:0]  r_px;
    logic signed [PW-1:0]  r_py;
    logic [31:0]           r_z1;
    logic [DATA_WIDTH-1:0] r_x2;
    logic [DATA_WIDTH-1:0] r_y2;
    logic [31:0]           r_z2;

    logic                  w_en1;
    logic                  w_en2;
    logic signed [PW-1:0]  w_px;
    logic signed [PW-1:0]  w_py;

    // Stage enables: a stage advances when it is empty or the stage after it advances
    assign w_en2         = !r_v2 || tready_data_o;
    assign w_en1         = !r_v1 || w_en2;
    assign tready_data_i = w_en1;

    // Sign-extend inputs to the full product width before multiplying by K_Q
    assign w_px = $signed({{EXT_W{x_i[DATA_WIDTH-1]}}, x_i}) * K_Q;
    assign w_py = $signed({{EXT_W{y_i[DATA_WIDTH-1]}}, y_i}) * K_Q;

    // Stage 1: full-precision products and z
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_v1 <= 1'b0;
            r_px <= '0;
            r_py <= '0;
            r_z1 <= '0;
        end else if (w_en1) begin
            r_v1 <= tvalid_data_i;
            r_px <= w_px;
            r_py <= w_py;
            r_z1 <= z_i;
        end
    end

    // Stage 2: optional rounding offset, drop fraction bits, truncate (|K| < 1, no overflow)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_v2 <= 1'b0;
            r_x2 <= '0;
            r_y2 <= '0;
            r_z2 <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            r_x2 <= DATA_WIDTH'((r_px + RND) >>> GAIN_FRAC);
            r_y2 <= DATA_WIDTH'((r_py + RND) >>> GAIN_FRAC);
            r_z2 <= r_z1;
        end
    end

    assign tvalid_data_o = r_v2;
    assign x_o           = r_x2;
    assign y_o           = r_y2;
    assign z_o           = r_z2;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// ---------------------------------------------------------------------------
// tb_cordic_gain_comp
// Directed and random checks of cordic_gain_comp: reset values, hand-computed
// gain results (both rounding builds), streaming latency/throughput,
// back-pressure ordering and stability, and reset in the middle of a stream.
// Build with CORDIC_GAIN_ROUND_EN defined to check the rounding variant.
// ---------------------------------------------------------------------------
module tb_cordic_gain_comp;

`ifdef CORDIC_GAIN_ROUND_EN
    localparam bit RND_EN = 1'b1;
`else
    localparam bit RND_EN = 1'b0;
`endif
    localparam longint K_Q     = 39797;
    localparam longint RND_OFS = RND_EN ? 64'sd32768 : 64'sd0;

    logic        aclk;
    logic        aresetn;
    logic        tvalid_data_i;
    logic        tready_data_i;
    logic [15:0] x_i;
    logic [15:0] y_i;
    logic [31:0] z_i;
    logic        tvalid_data_o;
    logic        tready_data_o;
    logic [15:0] x_o;
    logic [15:0] y_o;
    logic [31:0] z_o;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_lat = 1'b0;

    // Scoreboard: expected results and the cycle each beat was accepted
    logic [15:0] q_x[$];
    logic [15:0] q_y[$];
    logic [31:0] q_z[$];
    int          q_c[$];

    bit          prev_stall = 1'b0;
    logic [15:0] prev_x;
    logic [15:0] prev_y;
    logic [31:0] prev_z;

    cordic_gain_comp #(
        .DATA_WIDTH (16),
        .GAIN_FRAC  (16)
    ) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .tvalid_data_i (tvalid_data_i),
        .tready_data_i (tready_data_i),
        .x_i           (x_i),
        .y_i           (y_i),
        .z_i           (z_i),
        .tvalid_data_o (tvalid_data_o),
        .tready_data_o (tready_data_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .z_o           (z_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] gain(input logic [15:0] v);
        longint p;
        p = longint'($signed(v)) * K_Q + RND_OFS;
        return 16'(p >>> 16);
    endfunction

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            q_x.delete(); q_y.delete(); q_z.delete(); q_c.delete();
            prev_stall = 1'b0;
        end else begin
            // Two beats in flight means both stages are full
            check("tready_i", 32'(tready_data_i), 32'(!(q_x.size() == 2 && !tready_data_o)));
            if (prev_stall) begin
                check("stall_valid", 32'(tvalid_data_o), 32'(1));
                check("stall_x", 32'(x_o), 32'(prev_x));
                check("stall_y", 32'(y_o), 32'(prev_y));
                check("stall_z", z_o, prev_z);
            end
            if (tvalid_data_o && tready_data_o) begin
                if (q_x.size() == 0) begin
                    check("spurious_out", 32'(tvalid_data_o), 32'(0));
                end else begin
                    logic [15:0] ex, ey;
                    logic [31:0] ez;
                    int          ec;
                    ex = q_x.pop_front(); ey = q_y.pop_front();
                    ez = q_z.pop_front(); ec = q_c.pop_front();
                    check("out_x", 32'(x_o), 32'(ex));
                    check("out_y", 32'(y_o), 32'(ey));
                    check("out_z", z_o, ez);
                    if (chk_lat) check("latency", 32'(cyc - ec), 32'(2));
                end
            end
            if (tvalid_data_i && tready_data_i) begin
                q_x.push_back(gain(x_i));
                q_y.push_back(gain(y_i));
                q_z.push_back(z_i);
                q_c.push_back(cyc);
            end
            prev_stall = tvalid_data_o && !tready_data_o;
            prev_x = x_o; prev_y = y_o; prev_z = z_o;
        end
    end

    // One beat with tready_data_o=1, checked against hand-computed constants
    task automatic beat_dir(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [31:0] z, input logic [15:0] ex, input logic [15:0] ey);
        @(posedge aclk) #1;
        tvalid_data_i = 1'b1; x_i = x; y_i = y; z_i = z;
        @(posedge aclk) #1;
        tvalid_data_i = 1'b0;
        @(negedge aclk);
        check({tag, "_v_early"}, 32'(tvalid_data_o), 32'(0));
        @(negedge aclk);
        check({tag, "_v"}, 32'(tvalid_data_o), 32'(1));
        check({tag, "_x"}, 32'(x_o), 32'(ex));
        check({tag, "_y"}, 32'(y_o), 32'(ey));
        check({tag, "_z"}, z_o, z);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; tvalid_data_i = 1'b0; tready_data_o = 1'b1;
        x_i = '0; y_i = '0; z_i = '0;

        // Reset values
        repeat (3) @(negedge aclk);
        check("rst_valid", 32'(tvalid_data_o), 32'(0));
        check("rst_x", 32'(x_o), 32'(0));
        check("rst_y", 32'(y_o), 32'(0));
        check("rst_z", z_o, 32'(0));
        @(posedge aclk) #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_ready", 32'(tready_data_i), 32'(1));

        // Directed beats: 16384*K = 9949.25, 32767*K = 19897.89, -32768*K = -19898.5
        beat_dir("single", 16'd16384, 16'(-16384), 32'h1234_5678,
                 16'd9949, RND_EN ? 16'(-9949) : 16'(-9950));
        beat_dir("edge_max", 16'd32767, 16'd0, 32'hDEAD_BEEF,
                 RND_EN ? 16'd19898 : 16'd19897, 16'd0);
        beat_dir("edge_min", 16'd0, 16'h8000, 32'h0000_0001,
                 16'd0, RND_EN ? 16'(-19898) : 16'(-19899));

        // Streaming: back-to-back beats with no back-pressure
        chk_lat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge aclk) #1;
            tvalid_data_i = 1'b1;
            x_i = 16'($urandom); y_i = 16'($urandom); z_i = $urandom;
        end
        @(posedge aclk) #1;
        tvalid_data_i = 1'b0;
        idle(4);
        chk_lat = 1'b0;

        // Back-pressure: random valid and ready
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk) #1;
            tvalid_data_i = 1'($urandom);
            tready_data_o = 1'($urandom);
            x_i = 16'($urandom); y_i = 16'($urandom); z_i = $urandom;
        end
        @(posedge aclk) #1;
        tvalid_data_i = 1'b0; tready_data_o = 1'b1;
        idle(4);
        @(negedge aclk);
        check("drain_empty", 32'(q_x.size()), 32'(0));

        // Reset with two beats in flight
        @(posedge aclk) #1;
        tready_data_o = 1'b0; tvalid_data_i = 1'b1;
        x_i = 16'd1000; y_i = 16'(-2000); z_i = 32'hAAAA_0001;
        @(posedge aclk) #1;
        x_i = 16'd3000; y_i = 16'd4000; z_i = 32'hAAAA_0002;
        @(posedge aclk) #1;
        tvalid_data_i = 1'b0;
        @(negedge aclk);
        check("full_valid", 32'(tvalid_data_o), 32'(1));
        check("full_ready", 32'(tready_data_i), 32'(0));
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_valid", 32'(tvalid_data_o), 32'(0));
        check("midrst_x", 32'(x_o), 32'(0));
        check("midrst_z", z_o, 32'(0));
        check("midrst_ready", 32'(tready_data_i), 32'(1));
        @(posedge aclk);
        @(negedge aclk);
        @(posedge aclk) #1;
        aresetn = 1'b1; tready_data_o = 1'b1; chk_lat = 1'b1;
        tvalid_data_i = 1'b1; x_i = 16'd16384; y_i = 16'd32767; z_i = 32'h5555_AAAA;
        @(posedge aclk) #1;
        tvalid_data_i = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("post_rst_v", 32'(tvalid_data_o), 32'(1));
        check("post_rst_x", 32'(x_o), 32'(16'd9949));
        idle(3);
        @(negedge aclk);
        check("post_rst_empty", 32'(q_x.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
